// File: rtl/fetch_stage.sv
// fetch_stage: MIPS-style instruction fetch with a one-entry response buffer, redirect and HALT.
// Define FETCH_STAT_EN to build the fetch/stall statistics counters; otherwise they read 0.
package mips_pkg;
  typedef logic [31:0] Instruct;
  localparam logic [5:0] OP_HALT = 6'b010001;
endpackage

module fetch_stage #(
  parameter int unsigned     ADDR     = 32,
  parameter logic [ADDR-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [ADDR-1:0]     imem_addr,
  input  logic                imem_rvalid,
  input  logic [31:0]         imem_rdata,
  input  logic                stall,
  input  logic                redirect,
  input  logic [ADDR-1:0]     redirect_pc,
  output logic                id_valid,
  output mips_pkg::Instruct   id_instr,
  output logic [ADDR-1:0]     id_pc,
  output logic                halted,
  output logic [31:0]         fetch_count,
  output logic [31:0]         stall_count
);

  typedef enum logic [1:0] {INIT, RUN, BUF, HLT} state_t;

  state_t            state;
  logic [ADDR-1:0]   pc;
  logic [ADDR-1:0]   pc_inc;
  logic              req;
  logic              fire;
  mips_pkg::Instruct buf_instr;
  logic [ADDR-1:0]   buf_pc;

  assign imem_req  = req;
  assign imem_addr = pc;
  assign fire      = req & imem_rvalid;
  assign pc_inc    = pc + ADDR'(4);

  function automatic logic is_halt(input mips_pkg::Instruct instr);
    return instr[31:26] == mips_pkg::OP_HALT;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= INIT;
      pc       <= RESET_PC;
      req      <= 1'b0;
      id_valid <= 1'b0;
      id_instr <= '0;
      id_pc    <= '0;
      halted   <= 1'b0;
    end else if (redirect) begin
      // Redirect wins over everything, including a response landing this cycle.
      state    <= RUN;
      req      <= 1'b1;
      pc       <= {redirect_pc[ADDR-1:2], 2'b00};
      id_valid <= 1'b0;
      halted   <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          state <= RUN;
          req   <= 1'b1;
        end
        RUN: begin
          if (fire) begin
            pc <= pc_inc;
            if (stall) begin
              state <= BUF;
              req   <= 1'b0;
            end else begin
              id_valid <= 1'b1;
              id_instr <= imem_rdata;
              id_pc    <= pc;
              if (is_halt(imem_rdata)) begin
                state  <= HLT;
                req    <= 1'b0;
                halted <= 1'b1;
              end
            end
          end else if (!stall) begin
            id_valid <= 1'b0;
          end
        end
        BUF: begin
          if (!stall) begin
            id_valid <= 1'b1;
            id_instr <= buf_instr;
            id_pc    <= buf_pc;
            if (is_halt(buf_instr)) begin
              state  <= HLT;
              halted <= 1'b1;
            end else begin
              state <= RUN;
              req   <= 1'b1;
            end
          end
        end
        HLT: ;
        default: begin
          state <= INIT;
          req   <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the buffer payload has no reset; it is only read in BUF, which always follows a capture.
  always_ff @(posedge clk) begin
    if (state == RUN && fire && stall && !redirect) begin
      buf_instr <= imem_rdata;
      buf_pc    <= pc;
    end
  end

`ifdef FETCH_STAT_EN
  logic        id_load;
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

  assign id_load = !redirect && !stall && ((state == RUN && fire) || state == BUF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (id_load)           fetch_cnt <= fetch_cnt + 32'd1;
      if (stall && id_valid) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign fetch_count = fetch_cnt;
  assign stall_count = stall_cnt;
`else
  assign fetch_count = '0;
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table-driven cycle vectors for fetch_stage plus a hand-written async-reset sequence.
// Expected counter values depend on whether FETCH_STAT_EN is defined for the build.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        halted;
  logic [31:0] fetch_count;
  logic [31:0] stall_count;

  int n_tests;
  int n_fail;

  fetch_stage #(.ADDR(32), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .halted      (halted),
    .fetch_count (fetch_count),
    .stall_count (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] ADDI = 32'h2001_0005;
  localparam logic [31:0] SUBI = 32'h2402_0003;
  localparam logic [31:0] ORI  = 32'h3403_00FF;
  localparam logic [31:0] W4   = 32'h2004_0010;
  localparam logic [31:0] W5   = 32'h0085_1020;
  localparam logic [31:0] W6   = 32'h8C06_0000;
  localparam logic [31:0] W7   = 32'hAC07_0004;
  localparam logic [31:0] W8   = 32'h1108_0002;
  localparam logic [31:0] W9   = 32'h2009_0009;
  localparam logic [31:0] W10  = 32'h200A_000A;
  localparam logic [31:0] W11  = 32'h200B_000B;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;
  localparam logic [31:0] HALT = 32'h4400_0000;

  typedef struct {
    logic        st;
    logic        rd;
    logic [31:0] rpc;
    logic        rv;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic        idv;
    logic [31:0] idpc;
    logic [31:0] instr;
    logic        hlt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic st, input logic rd, input logic [31:0] rpc,
                             input logic rv, input logic [31:0] rdata,
                             input logic req, input logic [31:0] addr, input logic idv,
                             input logic [31:0] idpc, input logic [31:0] instr, input logic hlt);
    vec_t r;
    r.st = st; r.rd = rd; r.rpc = rpc; r.rv = rv; r.rdata = rdata;
    r.req = req; r.addr = addr; r.idv = idv; r.idpc = idpc; r.instr = instr; r.hlt = hlt;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic rd, input logic [31:0] rpc,
                       input logic rv, input logic [31:0] rdata);
    stall = st; redirect = rd; redirect_pc = rpc; imem_rvalid = rv; imem_rdata = rdata;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);

    //            st rd rpc           rv rdata | req addr          idv idpc          instr hlt
    tbl.push_back(v(0, 0, 0,            0, 0,    1, 32'h0,        0, 32'h0,        0,    0));
    tbl.push_back(v(0, 0, 0,            1, ADDI, 1, 32'h4,        1, 32'h0,        ADDI, 0));
    tbl.push_back(v(0, 0, 0,            1, SUBI, 1, 32'h8,        1, 32'h4,        SUBI, 0));
    tbl.push_back(v(0, 0, 0,            1, ORI,  1, 32'hC,        1, 32'h8,        ORI,  0));
    tbl.push_back(v(0, 0, 0,            0, JUNK, 1, 32'hC,        0, 32'h8,        ORI,  0));
    tbl.push_back(v(0, 0, 0,            0, JUNK, 1, 32'hC,        0, 32'h8,        ORI,  0));
    tbl.push_back(v(0, 0, 0,            1, W4,   1, 32'h10,       1, 32'hC,        W4,   0));
    tbl.push_back(v(0, 0, 0,            0, 0,    1, 32'h10,       0, 32'hC,        W4,   0));
    tbl.push_back(v(0, 0, 0,            0, 0,    1, 32'h10,       0, 32'hC,        W4,   0));
    tbl.push_back(v(0, 0, 0,            1, W5,   1, 32'h14,       1, 32'h10,       W5,   0));
    tbl.push_back(v(1, 0, 0,            1, W6,   0, 32'h18,       1, 32'h10,       W5,   0));
    tbl.push_back(v(1, 0, 0,            1, JUNK, 0, 32'h18,       1, 32'h10,       W5,   0));
    tbl.push_back(v(1, 0, 0,            0, 0,    0, 32'h18,       1, 32'h10,       W5,   0));
    tbl.push_back(v(1, 0, 0,            0, 0,    0, 32'h18,       1, 32'h10,       W5,   0));
    tbl.push_back(v(0, 0, 0,            0, 0,    1, 32'h18,       1, 32'h14,       W6,   0));
    tbl.push_back(v(0, 0, 0,            1, W7,   1, 32'h1C,       1, 32'h18,       W7,   0));
    tbl.push_back(v(1, 0, 0,            1, W8,   0, 32'h20,       1, 32'h18,       W7,   0));
    tbl.push_back(v(1, 1, 32'h103,      1, JUNK, 1, 32'h100,      0, 32'h18,       W7,   0));
    tbl.push_back(v(0, 0, 0,            1, W9,   1, 32'h104,      1, 32'h100,      W9,   0));
    tbl.push_back(v(0, 1, 32'h20,       1, JUNK, 1, 32'h20,       0, 32'h100,      W9,   0));
    tbl.push_back(v(0, 0, 0,            1, HALT, 0, 32'h24,       1, 32'h20,       HALT, 1));
    tbl.push_back(v(0, 0, 0,            1, JUNK, 0, 32'h24,       1, 32'h20,       HALT, 1));
    tbl.push_back(v(0, 0, 0,            0, 0,    0, 32'h24,       1, 32'h20,       HALT, 1));
    tbl.push_back(v(0, 1, 32'h40,       0, 0,    1, 32'h40,       0, 32'h20,       HALT, 0));
    tbl.push_back(v(0, 0, 0,            1, W10,  1, 32'h44,       1, 32'h40,       W10,  0));
    tbl.push_back(v(0, 1, 32'hFFFFFFFE, 0, 0,    1, 32'hFFFFFFFC, 0, 32'h40,       W10,  0));
    tbl.push_back(v(0, 0, 0,            1, W11,  1, 32'h0,        1, 32'hFFFFFFFC, W11,  0));
    tbl.push_back(v(1, 0, 0,            1, HALT, 0, 32'h4,        1, 32'hFFFFFFFC, W11,  0));
    tbl.push_back(v(0, 0, 0,            0, 0,    0, 32'h4,        1, 32'h0,        HALT, 1));

    tick();
    tick();
    check("reset req",      {31'b0, imem_req}, 32'h0);
    check("reset addr",     imem_addr,         32'h0);
    check("reset id_valid", {31'b0, id_valid}, 32'h0);
    check("reset id_instr", id_instr,          32'h0);
    check("reset id_pc",    id_pc,             32'h0);
    check("reset halted",   {31'b0, halted},   32'h0);
    check("reset fetch_cnt", fetch_count,      32'h0);
    check("reset stall_cnt", stall_count,      32'h0);

    rst = 1'b0;
    check("init req", {31'b0, imem_req}, 32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].st, tbl[i].rd, tbl[i].rpc, tbl[i].rv, tbl[i].rdata);
      tick();
      check($sformatf("row%0d req", i),      {31'b0, imem_req}, {31'b0, tbl[i].req});
      check($sformatf("row%0d addr", i),     imem_addr,         tbl[i].addr);
      check($sformatf("row%0d id_valid", i), {31'b0, id_valid}, {31'b0, tbl[i].idv});
      check($sformatf("row%0d id_pc", i),    id_pc,             tbl[i].idpc);
      check($sformatf("row%0d id_instr", i), id_instr,          tbl[i].instr);
      check($sformatf("row%0d halted", i),   {31'b0, halted},   {31'b0, tbl[i].hlt});
    end

`ifdef FETCH_STAT_EN
    check("stat fetch_count", fetch_count, 32'd12);
    check("stat stall_count", stall_count, 32'd7);
`else
    check("stat fetch_count", fetch_count, 32'd0);
    check("stat stall_count", stall_count, 32'd0);
`endif

    // Async reset while an instruction sits in the buffer.
    drive(0, 1, 32'h80, 0, 0);
    tick();
    drive(1, 0, 0, 1, W8);
    tick();
    check("buf req", {31'b0, imem_req}, 32'h0);
    check("buf addr", imem_addr, 32'h84);
    drive(0, 0, 0, 0, 0);
    #3;
    rst = 1'b1;
    #1;
    check("async req",      {31'b0, imem_req}, 32'h0);
    check("async addr",     imem_addr,         32'h0);
    check("async id_valid", {31'b0, id_valid}, 32'h0);
    check("async id_pc",    id_pc,             32'h0);
    check("async fetch_cnt", fetch_count,      32'h0);
    tick();
    rst = 1'b0;
    tick();
    check("restart req",  {31'b0, imem_req}, 32'h1);
    check("restart addr", imem_addr,         32'h0);
    drive(0, 0, 0, 1, W4);
    tick();
    check("restart id_pc",    id_pc,             32'h0);
    check("restart id_instr", id_instr,          W4);
    check("restart id_valid", {31'b0, id_valid}, 32'h1);
    check("restart addr2",    imem_addr,         32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
